// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared fetch-stage constants, state codes and buffer entry type
// Contents: INST_WIDTH, PC_INC, DEFAULT_RESET_PC, FETCH_* state codes,
//           fetch_entry_t {inst, pc}, align_pc() word-alignment helper.
package arm_defs;

    localparam int          INST_WIDTH       = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] FETCH_RUN    = 2'd0;
    localparam logic [1:0] FETCH_WAIT   = 2'd1;
    localparam logic [1:0] FETCH_FLUSH  = 2'd2;
    localparam logic [1:0] FETCH_HALTED = 2'd3;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [31:0]           pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arm_fetch_if.sv
// rtl/arm_fetch_if.sv - instruction-memory and decode handshakes of the fetch stage
// Signals: imem_req/imem_addr/imem_ready (request), imem_rvalid/imem_rdata (response),
//          inst_valid/inst/inst_pc/inst_ready (decode side).
// Modports: master = fetch stage, slave = memory + decoder environment.
interface arm_fetch_if;
    import arm_defs::*;

    logic                  imem_req;
    logic [31:0]           imem_addr;
    logic                  imem_ready;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst;
    logic [31:0]           inst_pc;
    logic                  inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, inst_ready
    );

endinterface

// File: rtl/arm_fetch_fifo.sv
// rtl/arm_fetch_fifo.sv - synchronous FIFO of {inst, pc} entries for the fetch stage
// Ports: clk, rst (sync, active high), push/push_data, pop, flush (clears, beats push/pop),
//        head (entry at read pointer), count, full, empty.
module arm_fetch_fifo
    import arm_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/arm_fetch.sv
// rtl/arm_fetch.sv - instruction fetch stage: PC, memory handshake, buffered decode handoff
// Ports: clk, rst (sync, active high), bus (arm_fetch_if.master: imem request/response
//        and decode valid/ready), redirect/redirect_pc (new PC + flush), halt (sticky stop),
//        fetch_pc (next address to request).
module arm_fetch
    import arm_defs::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    arm_fetch_if.master        bus,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    output logic [31:0]        fetch_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [1:0]    state;
    logic [31:0]   req_addr;
    logic          halting;
    logic          stop;
    logic          accept;
    logic          pending;
    logic          push;
    logic          pop;
    logic          flush;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    // halting keeps the stop sticky while an in-flight response is still being drained.
    assign stop    = halt || halting;
    assign flush   = stop || redirect;

    // Only one request may be outstanding, so a free slot always exists for its response.
    assign bus.imem_req  = !rst && !stop && (state == FETCH_RUN) && !full;
    assign bus.imem_addr = fetch_pc;
    assign accept        = bus.imem_req && bus.imem_ready;

    // A response is still owed if we were waiting/flushing and it has not arrived this cycle.
    assign pending = ((state == FETCH_WAIT) || (state == FETCH_FLUSH)) && !bus.imem_rvalid;

    assign push       = (state == FETCH_WAIT) && bus.imem_rvalid;
    assign pop        = !empty && bus.inst_ready;
    assign push_entry = '{inst: bus.imem_rdata, pc: req_addr};

    assign bus.inst_valid = (count != '0);
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;

    arm_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_RUN;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
            halting  <= 1'b0;
        end else if (stop) begin
            // Requests are masked while stopping, so accept cannot be set here.
            halting <= 1'b1;
            if (state != FETCH_HALTED) begin
                state <= pending ? FETCH_FLUSH : FETCH_HALTED;
            end
        end else if (redirect) begin
            fetch_pc <= align_pc(redirect_pc);
            // A request accepted in this very cycle still owes a response to discard.
            state    <= (pending || accept) ? FETCH_FLUSH : FETCH_RUN;
        end else begin
            case (state)
                FETCH_RUN: begin
                    if (accept) begin
                        req_addr <= fetch_pc;
                        fetch_pc <= fetch_pc + PC_INC;
                        state    <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.imem_rvalid) begin
                        state <= FETCH_RUN;
                    end
                end
                FETCH_FLUSH: begin
                    if (bus.imem_rvalid) begin
                        state <= FETCH_RUN;
                    end
                end
                default: begin
                    state <= FETCH_HALTED;
                end
            endcase
        end
    end

endmodule

// File: doc/arm_fetch.md
Name: arm_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Owns the fetch PC and issues word reads to instruction memory over a req/ready request and rvalid response handshake.
- Buffers returned words with their addresses in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts PC redirects (branches, writes to r15) and a sticky halt (SWI).

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- BUF_DEPTH, 2: instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request valid.
- imem_addr  output  32  word-aligned read address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; at most one response per accepted request, returned in order.
- imem_rdata  input  32  read data.
- inst_valid  output  1  FIFO head is valid.
- inst  output  32  instruction word at the FIFO head.
- inst_pc  output  32  address of the instruction at the FIFO head.
- inst_ready  input  1  decode consumes the head this cycle.
- redirect  input  1  load a new fetch PC and flush.
- redirect_pc  input  32  new PC; bits [1:0] are ignored and forced to 0.
- halt  input  1  stop fetching; sticky until rst.
- fetch_pc  output  32  next address to request.

Behaviour:
- Reset values (sync rst=1): imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_pc=RESET_PC, FIFO empty, state=RUN.
- States:
  - RUN: may request.
  - WAIT: one request is outstanding.
  - FLUSH: an outstanding response must be discarded.
  - HALTED: idle.
- imem_req=1 only when state=RUN and count<BUF_DEPTH. Only one request is ever outstanding, so a slot is always reserved for its response.
- imem_addr=fetch_pc.
- Request accepted (imem_req & imem_ready): fetch_pc <= fetch_pc+4, mod 2^32 (0xFFFF_FFFC wraps to 0). The accepted address is latched as req_addr and the state moves to WAIT.
- WAIT & imem_rvalid: push {imem_rdata, req_addr} into the FIFO and return to RUN.
- imem_rvalid outside WAIT or FLUSH is ignored.
- Decode side:
  - inst_valid = (count != 0); inst and inst_pc come from the head.
  - Pop on inst_valid & inst_ready.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - The FIFO uses wrap-around read/write pointers mod BUF_DEPTH.
- Latency: with imem_ready=1 and a 1-cycle response, the request goes out in cycle 0 after reset release, rvalid arrives in cycle 1, and inst_valid=1 in cycle 2. Sustained throughput is 1 instruction per 2 cycles.
- Redirect:
  - The FIFO is flushed (count=0) and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - A pop or push in the same cycle is discarded; redirect has priority.
  - If the state was WAIT and imem_rvalid is not also asserted that cycle, go to FLUSH; otherwise go to RUN.
  - FLUSH & imem_rvalid: drop the data and go to RUN.
  - A further redirect while in FLUSH only updates fetch_pc.
  - An unaccepted request (req=1, ready=0) may be withdrawn by a redirect; the new address appears the next cycle.
- Halt:
  - Once asserted, no new request is issued, the FIFO is flushed, and inst_valid=0 from the next cycle.
  - Any outstanding response is absorbed and discarded (through FLUSH if needed), then the state is HALTED.
  - In HALTED, redirect is ignored.
  - halt and redirect in the same cycle: halt wins.
- Reset mid-operation: all state returns to its reset value. A response to a pre-reset request arriving after reset is ignored because the state is RUN.

Decomposition:
- Shared package arm_defs: fetch state encodings (FETCH_RUN, FETCH_WAIT, FETCH_FLUSH, FETCH_HALTED), INST_WIDTH=32, PC_INC=4, default RESET_PC.
- One sub-module: arm_fetch_fifo, a synchronous FIFO of {inst, pc} entries with push, pop, flush, count, full and empty.
- arm_fetch holds the FSM, the PC, and the memory handshake.

Test Plan:
- Reset then straight-line fetch, with ready=1, 1-cycle rvalid, rdata=addr^0xE000_0000 and inst_ready=1: decode sees inst_pc 0x0, 0x4, 0x8, 0xC in order with the matching inst; first inst_valid is 2 cycles after rst falls.
- Backpressure with inst_ready=0 for 10 cycles: exactly BUF_DEPTH=2 requests are issued and then imem_req=0. On release, entries 0x0 and 0x4 drain in order and the request for 0x8 follows.
- Redirect with a request outstanding: redirect_pc=0x103 while in WAIT with a 3-cycle response latency. The stale word is dropped, the next request goes to 0x100, and the first inst_pc seen is 0x100.
- Redirect, push and pop in the same cycle: FIFO ends empty, fetch_pc=redirect target, no stale inst_valid.
- Halt while an entry is buffered and a request is in flight: inst_valid=0 the next cycle, no imem_req after that, a later redirect is ignored, and rst restarts fetching at RESET_PC.
- PC wrap with RESET_PC=0xFFFF_FFF8: requests go to 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
